baccarat_dealer: RTL and testbench

- Sequential card source that fills the six hand slots (player 1-3, banker 1-3) in baccarat deal order.
- Slot outputs feed the hand-scoring logic directly. An empty slot always reads 0, so a partial hand scores correctly.
- A free-running 1..13 "deck" counter is sampled on each user step; the button timing supplies the randomness.
- Third-card draws are gated by external rule inputs, which see the up-to-date slot values.

---
 rtl/baccarat_dealer.sv | 123 ++++++++++++
 tb/tb_baccarat_dealer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_dealer.sv
// Baccarat card dealer: samples a free-running 1..DECK_MAX deck counter on each
// step-button edge and fills player/banker slots in deal order, with external third-card rules.
module baccarat_dealer #(
  parameter int unsigned DECK_MAX = 13,
  parameter int unsigned CARD_W   = 4
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              start,
  input  logic              step,
  input  logic              draw_p3,
  input  logic              draw_d3,
  output logic [CARD_W-1:0] pcard1,
  output logic [CARD_W-1:0] pcard2,
  output logic [CARD_W-1:0] pcard3,
  output logic [CARD_W-1:0] dcard1,
  output logic [CARD_W-1:0] dcard2,
  output logic [CARD_W-1:0] dcard3,
  output logic [CARD_W-1:0] deck_value,
  output logic              dealing,
  output logic              hand_done
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    DEAL_P1 = 4'd1,
    DEAL_D1 = 4'd2,
    DEAL_P2 = 4'd3,
    DEAL_D2 = 4'd4,
    CHK_P3  = 4'd5,
    DEAL_P3 = 4'd6,
    CHK_D3  = 4'd7,
    DEAL_D3 = 4'd8,
    DONE    = 4'd9
  } state_e;

  state_e            state_q, state_d;
  logic [CARD_W-1:0] p1_q, p2_q, p3_q, d1_q, d2_q, d3_q;
  logic [CARD_W-1:0] p1_d, p2_d, p3_d, d1_d, d2_d, d3_d;
  logic [CARD_W-1:0] deck_q, deck_d;
  logic              step_q;
  logic              dealing_q, dealing_d;
  logic              done_q, done_d;
  logic              step_edge;

  assign step_edge = step & ~step_q;
  assign deck_d    = (deck_q == CARD_W'(DECK_MAX)) ? CARD_W'(1) : deck_q + CARD_W'(1);

  // State, slot and deck registers; reset wins over any simultaneous start/step.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q   <= IDLE;
      p1_q      <= '0;
      p2_q      <= '0;
      p3_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      deck_q    <= CARD_W'(1);
      step_q    <= 1'b0;
      dealing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      p3_q      <= p3_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      d3_q      <= d3_d;
      deck_q    <= deck_d;
      step_q    <= step;
      dealing_q <= dealing_d;
      done_q    <= done_d;
    end
  end

  // Deal sequencing; each slot is written only from its own DEAL state.
  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          p1_d    = '0;
          p2_d    = '0;
          p3_d    = '0;
          d1_d    = '0;
          d2_d    = '0;
          d3_d    = '0;
          state_d = DEAL_P1;
        end
      end
      DEAL_P1: if (step_edge) begin p1_d = deck_q; state_d = DEAL_D1; end
      DEAL_D1: if (step_edge) begin d1_d = deck_q; state_d = DEAL_P2; end
      DEAL_P2: if (step_edge) begin p2_d = deck_q; state_d = DEAL_D2; end
      DEAL_D2: if (step_edge) begin d2_d = deck_q; state_d = CHK_P3;  end
      CHK_P3:  state_d = draw_p3 ? DEAL_P3 : CHK_D3;
      DEAL_P3: if (step_edge) begin p3_d = deck_q; state_d = CHK_D3;  end
      CHK_D3:  state_d = draw_d3 ? DEAL_D3 : DONE;
      DEAL_D3: if (step_edge) begin d3_d = deck_q; state_d = DONE;    end
      default: state_d = IDLE;
    endcase
    dealing_d = (state_d != IDLE) && (state_d != DONE);
    done_d    = (state_d == DONE);
  end

  assign pcard1     = p1_q;
  assign pcard2     = p2_q;
  assign pcard3     = p3_q;
  assign dcard1     = d1_q;
  assign dcard2     = d2_q;
  assign dcard3     = d3_q;
  assign deck_value = deck_q;
  assign dealing    = dealing_q;
  assign hand_done  = done_q;

endmodule

// File: tb/tb_baccarat_dealer.sv
// Scoreboard bench for baccarat_dealer: stimulus predicts each hand from a
// cycle-count deck model, an independent monitor compares slots when hand_done rises.
module tb_baccarat_dealer;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic       draw_p3 = 1'b0;
  logic       draw_d3 = 1'b0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, deck_value;
  logic       dealing, hand_done;

  baccarat_dealer dut (
    .clk(clk), .resetb(resetb), .start(start), .step(step),
    .draw_p3(draw_p3), .draw_d3(draw_d3),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .deck_value(deck_value), .dealing(dealing), .hand_done(hand_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p1, d1, p2, d2, p3, d3;
  } hand_t;

  hand_t       exp_q[$];
  int          errs = 0;
  int          checks = 0;
  int unsigned n_rel = 0;
  bit          deck_ok = 1'b0;
  bit          done_prev = 1'b0;

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Deck model: cycles elapsed since the last reset edge, mod 13, plus one.
  always @(posedge clk) begin
    if (!resetb) begin
      n_rel   <= 0;
      deck_ok <= 1'b1;
    end else begin
      n_rel <= n_rel + 1;
    end
  end

  function automatic int deck_m();
    return int'(n_rel % 13) + 1;
  endfunction

  always @(negedge clk) begin
    if (deck_ok) check("deck_value", int'(deck_value), deck_m());
  end

  // Hand monitor: pop the predicted hand whenever hand_done rises.
  always @(negedge clk) begin
    hand_t h;
    if (hand_done && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_hand_done", 1, 0);
      end else begin
        h = exp_q.pop_front();
        check("pcard1", int'(pcard1), h.p1);
        check("dcard1", int'(dcard1), h.d1);
        check("pcard2", int'(pcard2), h.p2);
        check("dcard2", int'(dcard2), h.d2);
        check("pcard3", int'(pcard3), h.p3);
        check("dcard3", int'(dcard3), h.d3);
      end
    end
    done_prev = hand_done;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_slots"}, int'(pcard1) + int'(pcard2) + int'(pcard3)
                        + int'(dcard1) + int'(dcard2) + int'(dcard3), 0);
  endtask

  // Release step for two cycles, wait for the wanted deck value (0 = any), then raise step.
  task automatic deal_at(input int target, input int hold, output int val);
    int k;
    step = 1'b0;
    tick();
    tick();
    k = 0;
    while (target != 0 && deck_m() != target && k < 40) begin
      tick();
      k++;
    end
    if (target != 0 && deck_m() != target) check("deck_wait_timeout", deck_m(), target);
    val  = deck_m();
    step = 1'b1;
    tick();
    repeat (hold) tick();
  endtask

  task automatic start_hand(input bit with_step);
    start = 1'b1;
    if (with_step) step = 1'b1;
    tick();
    start = 1'b0;
    check_all_zero("start_clear");
    check("start_dealing", int'(dealing), 1);
    check("start_hand_done", int'(hand_done), 0);
  endtask

  task automatic play_hand(input int t1, t2, t3, t4, t5, t6, input bit dp3, dd3,
                           input int hold, input bit poke, input bit step_with_start);
    hand_t h;
    int    lat;
    draw_p3 = dp3;
    draw_d3 = dd3;
    start_hand(step_with_start);
    deal_at(t1, hold, h.p1);
    if (hold > 0) begin
      check("hold_pcard1", int'(pcard1), h.p1);
      check("hold_dcard1_empty", int'(dcard1), 0);
    end
    deal_at(t2, 0, h.d1);
    deal_at(t3, 0, h.p2);
    if (poke) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check("poke_pcard1_kept", int'(pcard1), h.p1);
      check("poke_dealing", int'(dealing), 1);
    end
    deal_at(t4, 0, h.d2);
    h.p3 = 0;
    h.d3 = 0;
    if (dp3) deal_at(t5, 0, h.p3);
    if (dd3) begin
      step = 1'b0;
      tick();
      check("pre_d3_pcard3", int'(pcard3), h.p3);
      check("pre_d3_dcard3_empty", int'(dcard3), 0);
      deal_at(t6, 0, h.d3);
    end
    exp_q.push_back(h);
    lat = dd3 ? 0 : (dp3 ? 1 : 2);
    for (int i = 0; i < lat; i++) begin
      check("hand_done_early", int'(hand_done), 0);
      tick();
    end
    check("hand_done_latency", int'(hand_done), 1);
    check("done_dealing", int'(dealing), 0);
    step = 1'b0;
    tick();
  endtask

  initial begin
    int v;
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    check("reset_deck", int'(deck_value), 1);
    check("reset_hand_done", int'(hand_done), 0);
    for (int i = 0; i < 30; i++) begin
      check_all_zero("idle");
      check("idle_dealing", int'(dealing), 0);
      tick();
    end

    play_hand(5, 12, 1, 9, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    play_hand(5, 12, 1, 9, 7, 13, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    play_hand(3, 0, 0, 0, 0, 0, 1'b0, 1'b1, 20, 1'b0, 1'b0);
    play_hand(0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    play_hand(13, 1, 0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Reset mid-hand with start and a step edge arriving at the same edge.
    draw_p3 = 1'b0;
    draw_d3 = 1'b0;
    start_hand(1'b0);
    deal_at(0, 0, v);
    deal_at(0, 0, v);
    check("pre_reset_dcard1", int'(dcard1), v);
    step = 1'b0;
    tick();
    resetb = 1'b0;
    start  = 1'b1;
    step   = 1'b1;
    tick();
    resetb = 1'b1;
    start  = 1'b0;
    step   = 1'b0;
    check_all_zero("midhand_reset");
    check("midhand_reset_dealing", int'(dealing), 0);
    check("midhand_reset_deck", int'(deck_value), 1);
    repeat (3) tick();
    check("after_reset_idle", int'(dealing), 0);

    for (int i = 0; i < 10; i++) begin
      play_hand(int'($urandom_range(1, 13)), int'($urandom_range(1, 13)),
                int'($urandom_range(1, 13)), int'($urandom_range(1, 13)),
                int'($urandom_range(1, 13)), int'($urandom_range(1, 13)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 5)) tick();
    end

    repeat (4) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
